// File: rtl/viterbi_pkg.sv
// viterbi_pkg: shared constants, node-word field positions and FSM encoding
// for the Viterbi trellis controller.
package viterbi_pkg;
    localparam int NUM_STATES = 4;
    localparam int METRIC_W   = 5;
    localparam int METRIC_MSB = 6;
    localparam int METRIC_LSB = 2;
    localparam int FLAG_MSB   = 1;
    localparam int FLAG_LSB   = 0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_SYM,
        S_ISSUE,
        S_WAIT_PM,
        S_STORE,
        S_FINAL,
        S_DONE
    } state_t;
endpackage

// File: rtl/viterbi_min4_select.sv
// viterbi_min4_select: combinational argmin over four path metrics,
// ties resolve to the lowest state index.
module viterbi_min4_select
    import viterbi_pkg::*;
(
    input  logic [NUM_STATES-1:0][METRIC_W-1:0] metrics,
    output logic [1:0]                          idx,
    output logic [METRIC_W-1:0]                 min_val
);
    logic lo_sel, hi_sel;
    logic [METRIC_W-1:0] lo, hi;

    // strict compares keep the lower index on ties at both levels
    always_comb begin
        lo_sel  = metrics[1] < metrics[0];
        hi_sel  = metrics[3] < metrics[2];
        lo      = lo_sel ? metrics[1] : metrics[0];
        hi      = hi_sel ? metrics[3] : metrics[2];
        idx     = (hi < lo) ? {1'b1, hi_sel} : {1'b0, lo_sel};
        min_val = (hi < lo) ? hi : lo;
    end
endmodule

// File: rtl/viterbi_trellis_controller.sv
// viterbi_trellis_controller: sequences the 4-state path-metric step unit over a
// block of columns, stores node words to trellis memory and reports the best end state.
module viterbi_trellis_controller
    import viterbi_pkg::*;
#(
    parameter int NUM_STEPS  = 10,
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 6,
    parameter int INIT_BIAS  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  sym_valid,
    input  logic [1:0]            sym_data,
    output logic                  sym_ready,
    output logic                  pm_st,
    output logic [1:0]            pm_code,
    output logic [DATA_WIDTH-1:0] pm_in0,
    output logic [DATA_WIDTH-1:0] pm_in1,
    output logic [DATA_WIDTH-1:0] pm_in2,
    output logic [DATA_WIDTH-1:0] pm_in3,
    input  logic [DATA_WIDTH-1:0] pm_out0,
    input  logic [DATA_WIDTH-1:0] pm_out1,
    input  logic [DATA_WIDTH-1:0] pm_out2,
    input  logic [DATA_WIDTH-1:0] pm_out3,
    input  logic                  pm_done,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  busy,
    output logic                  block_done,
    output logic [1:0]            best_state,
    output logic [METRIC_W-1:0]   best_metric,
    output logic [3:0]            step_cnt
);
    localparam logic [3:0] LAST = 4'(NUM_STEPS - 1);
    localparam logic [DATA_WIDTH-1:0] INIT_W = DATA_WIDTH'(INIT_BIAS << METRIC_LSB);
    localparam logic [NUM_STATES-1:0][DATA_WIDTH-1:0] INIT_NODES =
        {{(NUM_STATES-1){INIT_W}}, {DATA_WIDTH{1'b0}}};

    // metrics are never saturated here, so the worst-case growth must fit 5 bits
    if (NUM_STEPS < 1 || NUM_STEPS > 15 || NUM_STEPS * 2 + INIT_BIAS > 31) begin : g_bad_params
        $error("viterbi_trellis_controller: NUM_STEPS/INIT_BIAS out of range");
    end

    state_t state, next;
    logic [1:0] node;
    logic [NUM_STATES-1:0][DATA_WIDTH-1:0] nodes;
    logic [NUM_STATES-1:0][METRIC_W-1:0] metrics;
    logic [1:0] min_idx;
    logic [METRIC_W-1:0] min_val;

    for (genvar i = 0; i < NUM_STATES; i++) begin : g_m
        assign metrics[i] = nodes[i][METRIC_MSB:METRIC_LSB];
    end

    viterbi_min4_select u_min4 (
        .metrics (metrics),
        .idx     (min_idx),
        .min_val (min_val)
    );

    assign pm_in0    = nodes[0];
    assign pm_in1    = nodes[1];
    assign pm_in2    = nodes[2];
    assign pm_in3    = nodes[3];
    assign busy      = state != S_IDLE;
    assign mem_addr  = ADDR_WIDTH'({step_cnt, node});
    assign mem_wdata = DATA_WIDTH'({1'b0, nodes[node][METRIC_MSB:METRIC_LSB],
                                    nodes[node][FLAG_MSB:FLAG_LSB]});

    always_ff @(posedge clk) state <= rst ? S_IDLE : next;

    always_comb begin
        next       = state;
        sym_ready  = 1'b0;
        pm_st      = 1'b0;
        mem_we     = 1'b0;
        block_done = 1'b0;
        case (state)
            S_IDLE:     next = start ? S_WAIT_SYM : S_IDLE;
            S_WAIT_SYM: begin
                sym_ready = 1'b1;
                next      = sym_valid ? S_ISSUE : S_WAIT_SYM;
            end
            S_ISSUE:    begin
                pm_st = 1'b1;
                next  = S_WAIT_PM;
            end
            S_WAIT_PM:  next = pm_done ? S_STORE : S_WAIT_PM;
            S_STORE:    begin
                // a column in flight is dropped as soon as reset is seen
                mem_we = !rst;
                next   = (node != 2'd3) ? S_STORE : (step_cnt == LAST) ? S_FINAL : S_WAIT_SYM;
            end
            S_FINAL:    next = S_DONE;
            S_DONE:     begin
                block_done = 1'b1;
                next       = S_IDLE;
            end
            default:    next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            step_cnt    <= '0;
            node        <= '0;
            pm_code     <= '0;
            nodes       <= INIT_NODES;
            best_state  <= '0;
            best_metric <= '0;
        end else begin
            if (state == S_IDLE && start) begin
                step_cnt <= '0;
                nodes    <= INIT_NODES;
            end
            if (state == S_WAIT_SYM && sym_valid)
                pm_code <= sym_data;
            if (state == S_WAIT_PM && pm_done)
                nodes <= {pm_out3, pm_out2, pm_out1, pm_out0};
            if (state == S_STORE) begin
                node <= node + 2'd1;
                if (node == 2'd3 && step_cnt != LAST)
                    step_cnt <= step_cnt + 4'd1;
            end
            if (state == S_FINAL) begin
                best_state  <= min_idx;
                best_metric <= min_val;
            end
        end
    end
endmodule

// File: tb/tb_viterbi_trellis_controller.sv
// tb_viterbi_trellis_controller: scoreboard bench with a behavioural 3-cycle ACS
// step unit; expected memory writes are queued when the step unit answers.
module tb_viterbi_trellis_controller;
    localparam int NS = 10;
    localparam logic [3:0][7:0] INIT = {8'h20, 8'h20, 8'h20, 8'h00};

    logic clk = 1'b0, rst = 1'b1, start = 1'b0, sym_valid = 1'b0, pm_done = 1'b0;
    logic [1:0] sym_data = '0;
    logic [7:0] pm_out0 = '0, pm_out1 = '0, pm_out2 = '0, pm_out3 = '0;
    logic sym_ready, pm_st, mem_we, busy, block_done;
    logic [1:0] pm_code, best_state;
    logic [7:0] pm_in0, pm_in1, pm_in2, pm_in3, mem_wdata;
    logic [5:0] mem_addr;
    logic [4:0] best_metric;
    logic [3:0] step_cnt;

    always #5 clk = ~clk;

    viterbi_trellis_controller dut (
        .clk(clk), .rst(rst), .start(start), .sym_valid(sym_valid), .sym_data(sym_data),
        .sym_ready(sym_ready), .pm_st(pm_st), .pm_code(pm_code),
        .pm_in0(pm_in0), .pm_in1(pm_in1), .pm_in2(pm_in2), .pm_in3(pm_in3),
        .pm_out0(pm_out0), .pm_out1(pm_out1), .pm_out2(pm_out2), .pm_out3(pm_out3),
        .pm_done(pm_done), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .busy(busy), .block_done(block_done), .best_state(best_state),
        .best_metric(best_metric), .step_cnt(step_cnt)
    );

    typedef struct {
        logic [5:0] addr;
        logic [7:0] data;
    } wr_t;

    wr_t exp_q[$];
    logic [3:0][7:0] mdl = INIT;
    logic [1:0] syms [NS];
    int n_checks = 0, n_errors = 0;
    int mdl_step = 0, n_writes = 0, n_done = 0, n_st = 0;
    bit force_last = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // K=3 (7,5) code; state = {u[t-1], u[t-2]}, next state = {u, s[1]}
    function automatic logic [7:0] acs(input logic [1:0] code, input logic [3:0][7:0] prev,
                                       input int ns);
        logic [1:0] nsb, s, c;
        logic [4:0] m [2];
        logic u, sel;
        nsb = 2'(ns);
        u   = nsb[1];
        for (int x = 0; x < 2; x++) begin
            s    = {nsb[0], 1'(x)};
            c    = {u ^ s[1] ^ s[0], u ^ s[0]};
            m[x] = prev[s][6:2] + 5'(int'(code[1] ^ c[1]) + int'(code[0] ^ c[0]));
        end
        sel = m[1] < m[0];
        return {1'b0, sel ? m[1] : m[0], 1'b0, sel};
    endfunction

    function automatic int argmin(input logic [3:0][7:0] w);
        int b = 0;
        for (int i = 1; i < 4; i++)
            if (w[i][6:2] < w[b][6:2]) b = i;
        return b;
    endfunction

    // behavioural step unit
    initial begin
        logic [1:0] code;
        logic [3:0][7:0] nxt;
        forever begin
            @(negedge clk);
            if (!rst && pm_st) begin
                code = pm_code;
                n_st++;
                chk("pm_in0", pm_in0, mdl[0]);
                chk("pm_in1", pm_in1, mdl[1]);
                chk("pm_in2", pm_in2, mdl[2]);
                chk("pm_in3", pm_in3, mdl[3]);
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    chk("hold_code", pm_code, code);
                    chk("hold_in3", pm_in3, mdl[3]);
                    chk("pm_st_once", pm_st, 0);
                end
                for (int n = 0; n < 4; n++) nxt[n] = acs(code, mdl, n);
                if (force_last && mdl_step == NS - 1) nxt = {8'h1C, 8'h10, 8'h10, 8'h24};
                for (int n = 0; n < 4; n++) exp_q.push_back('{6'(mdl_step * 4 + n), {1'b0, nxt[n][6:0]}});
                mdl = nxt;
                mdl_step++;
                {pm_out3, pm_out2, pm_out1, pm_out0} = nxt;
                pm_done = 1'b1;
                @(negedge clk);
                pm_done = 1'b0;
                {pm_out3, pm_out2, pm_out1, pm_out0} = {$urandom, $urandom};
            end
        end
    end

    // memory-write monitor
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            if (mem_we) begin
                n_writes++;
                if (exp_q.size() == 0) chk("unexpected_write", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    chk("mem_addr", mem_addr, e.addr);
                    chk("mem_wdata", mem_wdata, e.data);
                end
            end
            if (block_done) n_done++;
        end
    end

    task automatic run_block(input int stall_step, input bit poke, input int abort_step,
                             input int exp_state, input int exp_metric);
        int g;
        exp_q.delete();
        mdl = INIT;
        mdl_step = 0; n_writes = 0; n_done = 0; n_st = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        for (int i = 0; i < NS; i++) begin
            g = 0;
            while (!sym_ready) begin
                @(negedge clk);
                if (++g > 200) begin chk("sym_ready_timeout", 0, 1); return; end
            end
            chk("step_cnt", step_cnt, i);
            if (i == stall_step)
                repeat (5) begin
                    chk("stall_ready", sym_ready, 1);
                    chk("stall_no_st", pm_st, 0);
                    @(negedge clk);
                end
            if (poke && i == 4) begin
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
            sym_valid = 1'b1;
            sym_data  = syms[i];
            @(negedge clk);
            sym_valid = 1'b0;
            chk("ready_low_off_wait", sym_ready, 0);
            if ((poke && i == 5) || i == abort_step) begin
                g = 0;
                while (!(mem_we && (i != abort_step || mem_addr == 6'(i * 4 + 2)))) begin
                    @(negedge clk);
                    if (++g > 200) begin chk("store_timeout", 0, 1); return; end
                end
                if (i == abort_step) begin
                    rst = 1'b1;
                    #1 chk("we_drop_on_rst", mem_we, 0);
                    @(posedge clk);
                    #1;
                    chk("rst_busy", busy, 0);
                    chk("rst_step_cnt", step_cnt, 0);
                    chk("rst_pm_in0", pm_in0, 8'h00);
                    chk("rst_pm_in1", pm_in1, 8'h20);
                    @(negedge clk);
                    rst = 1'b0;
                    exp_q.delete();
                    return;
                end
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
        end
        g = 0;
        while (!block_done) begin
            @(negedge clk);
            if (++g > 200) begin chk("block_done_timeout", 0, 1); return; end
        end
        chk("best_state_model", best_state, argmin(mdl));
        chk("best_metric_model", best_metric, mdl[argmin(mdl)][6:2]);
        if (exp_state >= 0) begin
            chk("best_state", best_state, exp_state);
            chk("best_metric", best_metric, exp_metric);
        end
        repeat (3) @(negedge clk);
        chk("busy_after_done", busy, 0);
        chk("block_done_count", n_done, 1);
        chk("write_count", n_writes, 4 * NS);
        chk("queue_empty", exp_q.size(), 0);
        chk("pm_st_count", n_st, NS);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset_busy", busy, 0);
        chk("reset_step_cnt", step_cnt, 0);
        chk("reset_pm_in0", pm_in0, 8'h00);
        chk("reset_pm_in1", pm_in1, 8'h20);
        chk("reset_pm_in3", pm_in3, 8'h20);
        chk("reset_best", {best_state, best_metric}, 0);
        chk("reset_we", mem_we, 0);
        chk("reset_ready", sym_ready, 0);
        sym_valid = 1'b1;
        @(negedge clk);
        sym_valid = 1'b0;
        chk("idle_ignores_sym", busy, 0);

        for (int i = 0; i < NS; i++) syms[i] = 2'b00;
        run_block(-1, 1'b0, -1, 0, 0);

        syms[3] = 2'b11;
        run_block(-1, 1'b0, -1, 0, 2);

        syms[3] = 2'b00;
        run_block(2, 1'b0, -1, 0, 0);

        run_block(-1, 1'b1, -1, 0, 0);

        for (int i = 0; i < NS; i++) syms[i] = 2'($urandom_range(0, 3));
        run_block(-1, 1'b0, -1, -1, 0);

        force_last = 1'b1;
        run_block(-1, 1'b0, -1, 1, 4);
        force_last = 1'b0;

        run_block(-1, 1'b0, 6, -1, 0);
        chk("best_after_rst", {best_state, best_metric}, 0);

        for (int i = 0; i < NS; i++) syms[i] = 2'($urandom_range(0, 3));
        run_block(1, 1'b0, -1, -1, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
